pipe_skid_reg: RTL and testbench

Parametrised pipeline-stage register that replaces the fixed-width fetch/decode latch with a generic ready/valid stage. It carries an opaque payload of `DATA_W` bits and holds up to two entries (main + skid), so `in_ready` is registered and cuts the combinational stall path. On flush it converts held contents to a programmable bubble encoding. It sits between any two pipeline stages (IF/ID, ID/EX, ...) and exports saturating stall and flush-drop counters for performance analysis.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/sat_counter.sv | 32 +++
 rtl/pipe_skid_reg.sv | 134 +++++++++++++
 tb/tb_pipe_skid_reg.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for ready/valid pipeline stage registers.
package pipe_pkg;

  // Occupancy of a two-entry (main + skid) stage.
  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } pipe_state_t;

  // IF/ID payload layout: {instruction, pc, pc_jump}.
  localparam int unsigned InstrW    = 32;
  localparam int unsigned PcW       = 32;
  localparam int unsigned PcJumpW   = 32;
  localparam int unsigned IfIdDataW = InstrW + PcW + PcJumpW;

  // Number of valid entries held in a given state.
  function automatic logic [1:0] held_entries(pipe_state_t st);
    logic [1:0] n;
    case (st)
      StOne:   n = 2'd1;
      StFull:  n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: an increment that would overflow clamps to all-ones.
module sat_counter #(
  parameter int unsigned W     = 16,
  parameter int unsigned INC_W = 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     count_o
);

  logic [W-1:0] count_q, count_d;
  logic [W:0]   sum;

  // One extra bit catches the carry out; any carry means saturate.
  always_comb begin
    sum     = {1'b0, count_q} + {{(W + 1 - INC_W){1'b0}}, inc_i};
    count_d = sum[W] ? {W{1'b1}} : sum[W-1:0];
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// Two-entry ready/valid pipeline stage with registered in_ready, flush-to-bubble
// and saturating stall / flush-drop counters.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W = IfIdDataW,
  parameter logic [DATA_W-1:0] BUBBLE = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W  = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CNT_W-1:0]  stall_cycles_o,
  output logic [CNT_W-1:0]  flush_drops_o
);

  pipe_state_t       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic       in_fire;
  logic       out_fire;
  logic       stall_evt;
  logic [1:0] drop_inc;

  assign in_fire   = in_valid_i && in_ready_q;
  assign out_fire  = out_valid_q && out_ready_i;
  assign stall_evt = out_valid_q && !out_ready_i;

  // Next state and payload moves; flush overrides normal transitions.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = StEmpty;
      main_d  = BUBBLE;
      skid_d  = BUBBLE;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data_i;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_d = in_data_i;
          end else if (in_fire) begin
            state_d = StFull;
            skid_d  = in_data_i;
          end else if (out_fire) begin
            state_d = StEmpty;
            main_d  = BUBBLE;
          end
        end
        StFull: begin
          // in_ready_q is low here, so only a drain can happen.
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
            skid_d  = BUBBLE;
          end
        end
        default: begin
          state_d = StEmpty;
          main_d  = BUBBLE;
          skid_d  = BUBBLE;
        end
      endcase
    end
    in_ready_d  = (state_d != StFull);
    out_valid_d = (state_d != StEmpty);
  end

  // Entries lost to a flush: held ones not leaving this cycle plus any accepted input.
  always_comb begin
    drop_inc = '0;
    if (flush_i) begin
      drop_inc = held_entries(state_q) - {1'b0, out_fire} + {1'b0, in_fire};
    end
  end

  // Stage registers; in_ready and out_valid are registered to keep outputs glitch-free.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= StEmpty;
      main_q      <= BUBBLE;
      skid_q      <= BUBBLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  sat_counter #(
    .W     (CNT_W),
    .INC_W (1)
  ) u_stall_cnt (
    .clock   (clock),
    .rst     (rst),
    .inc_i   (stall_evt),
    .count_o (stall_cycles_o)
  );

  sat_counter #(
    .W     (CNT_W),
    .INC_W (2)
  ) u_drop_cnt (
    .clock   (clock),
    .rst     (rst),
    .inc_i   (drop_inc),
    .count_o (flush_drops_o)
  );

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench for pipe_skid_reg: reset, streaming, skid, flush and saturation.
module tb_pipe_skid_reg;

  localparam int unsigned     DW  = 16;
  localparam int unsigned     CW  = 4;
  localparam logic [DW-1:0]   BUB = 16'hB0B0;
  localparam logic [DW-1:0]   DA  = 16'h1111;
  localparam logic [DW-1:0]   DB  = 16'h2222;
  localparam logic [DW-1:0]   DC  = 16'h3333;

  logic          clock;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_drops;

  int n_vec;
  int n_err;

  pipe_skid_reg #(
    .DATA_W (DW),
    .BUBBLE (BUB),
    .CNT_W  (CW)
  ) dut (
    .clock          (clock),
    .rst            (rst),
    .flush_i        (flush),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .stall_cycles_o (stall_cycles),
    .flush_drops_o  (flush_drops)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = DA; out_ready = 1'b0;
    tick(); tick();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
    n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready got %0b want 1", in_ready); end
    n_vec++; if (out_data !== BUB) begin n_err++; $display("FAIL rst_out_data got %h want %h", out_data, BUB); end
    n_vec++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL rst_stall got %0d want 0", stall_cycles); end
    n_vec++; if (flush_drops !== 4'd0) begin n_err++; $display("FAIL rst_drops got %0d want 0", flush_drops); end
    rst = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst_accept_valid got %0b want 1", out_valid); end
    n_vec++; if (out_data !== DA) begin n_err++; $display("FAIL rst_accept_data got %h want %h", out_data, DA); end
    in_valid = 1'b0;
  endtask

  task automatic test_stream();
    logic [DW-1:0] seq [3];
    seq[0] = DA; seq[1] = DB; seq[2] = DC;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = seq[i];
      tick();
      n_vec++; if (out_valid !== 1'b1 || out_data !== seq[i]) begin
        n_err++; $display("FAIL stream_%0d got v=%0b d=%h want v=1 d=%h", i, out_valid, out_data, seq[i]);
      end
      n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_ready_%0d got %0b want 1", i, in_ready); end
    end
    in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b0 || out_data !== BUB) begin
      n_err++; $display("FAIL stream_drain got v=%0b d=%h want v=0 d=%h", out_valid, out_data, BUB);
    end
    n_vec++; if (stall_cycles !== 4'd0) begin n_err++; $display("FAIL stream_stall got %0d want 0", stall_cycles); end
  endtask

  task automatic test_skid();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = DA;
    tick();
    // A now presented; downstream stalls while B arrives.
    out_ready = 1'b0; in_data = DB;
    tick();
    n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL skid_in_ready got %0b want 0", in_ready); end
    n_vec++; if (out_data !== DA) begin n_err++; $display("FAIL skid_hold_a got %h want %h", out_data, DA); end
    n_vec++; if (stall_cycles !== 4'd1) begin n_err++; $display("FAIL skid_stall1 got %0d want 1", stall_cycles); end
    // C must be refused while FULL.
    in_data = DC;
    tick();
    n_vec++; if (stall_cycles !== 4'd2) begin n_err++; $display("FAIL skid_stall2 got %0d want 2", stall_cycles); end
    tick();
    n_vec++; if (stall_cycles !== 4'd3 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL skid_stall3 got s=%0d r=%0b want s=3 r=0", stall_cycles, in_ready);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    n_vec++; if (out_valid !== 1'b1 || out_data !== DB) begin
      n_err++; $display("FAIL skid_release_b got v=%0b d=%h want v=1 d=%h", out_valid, out_data, DB);
    end
    n_vec++; if (in_ready !== 1'b1 || stall_cycles !== 4'd3) begin
      n_err++; $display("FAIL skid_release_state got r=%0b s=%0d want r=1 s=3", in_ready, stall_cycles);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0 || out_data !== BUB) begin
      n_err++; $display("FAIL skid_empty got v=%0b d=%h want v=0 d=%h", out_valid, out_data, BUB);
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    in_valid = 1'b1; in_data = DA;
    tick();
    in_data = DB;
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++; if (in_ready !== 1'b0 || stall_cycles !== 4'd2) begin
      n_err++; $display("FAIL ff_full got r=%0b s=%0d want r=0 s=2", in_ready, stall_cycles);
    end
    out_ready = 1'b1;
    tick();
    n_vec++; if (out_data !== DB || in_ready !== 1'b1) begin
      n_err++; $display("FAIL ff_drain got d=%h r=%0b want d=%h r=1", out_data, in_ready, DB);
    end
    // B held, not leaving; C accepted then discarded.
    out_ready = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = DC;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (out_valid !== 1'b0 || out_data !== BUB) begin
      n_err++; $display("FAIL ff_bubble got v=%0b d=%h want v=0 d=%h", out_valid, out_data, BUB);
    end
    n_vec++; if (flush_drops !== 4'd2) begin n_err++; $display("FAIL ff_drops got %0d want 2", flush_drops); end
    n_vec++; if (stall_cycles !== 4'd3 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL ff_after got s=%0d r=%0b want s=3 r=1", stall_cycles, in_ready);
    end
  endtask

  task automatic test_flush_out_fire();
    do_reset();
    in_valid = 1'b1; in_data = DA;
    tick();
    out_ready = 1'b1; in_data = DB; flush = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b1 || out_data !== DA) begin
      n_err++; $display("FAIL fo_present got v=%0b d=%h want v=1 d=%h", out_valid, out_data, DA);
    end
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_vec++; if (flush_drops !== 4'd1) begin n_err++; $display("FAIL fo_drops got %0d want 1", flush_drops); end
    n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== BUB) begin
      n_err++; $display("FAIL fo_empty got v=%0b r=%0b d=%h want v=0 r=1 d=%h", out_valid, in_ready,
                        out_data, BUB);
    end
    tick();
    n_vec++; if (out_valid !== 1'b0 || flush_drops !== 4'd1) begin
      n_err++; $display("FAIL fo_stay got v=%0b drops=%0d want v=0 drops=1", out_valid, flush_drops);
    end
  endtask

  task automatic test_flush_full_out_fire();
    do_reset();
    in_valid = 1'b1; in_data = DA;
    tick();
    in_data = DB;
    tick();
    // FULL with A leaving this cycle: only B is dropped.
    in_valid = 1'b0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    n_vec++; if (flush_drops !== 4'd1 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL ffo_drops got drops=%0d v=%0b want drops=1 v=0", flush_drops, out_valid);
    end
  endtask

  task automatic test_saturation();
    int exp_cnt;
    do_reset();
    in_valid = 1'b1; in_data = DA;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      exp_cnt = (i + 1 > 15) ? 15 : i + 1;
      n_vec++; if (stall_cycles !== exp_cnt[CW-1:0]) begin
        n_err++; $display("FAIL sat_%0d got %0d want %0d", i, stall_cycles, exp_cnt);
      end
    end
    n_vec++; if (out_data !== DA) begin n_err++; $display("FAIL sat_hold got %h want %h", out_data, DA); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_stream();
    test_skid();
    test_flush_full();
    test_flush_out_fire();
    test_flush_full_out_fire();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
